// File: rtl/i2c_slave_responder_if.sv
// Byte-level handshake between the I2C target and its local register file / FIFO,
// plus the bus clock input from the I2C master.
interface i2c_slave_responder_if;
  logic       i2c_sclk;
  logic       rx_nack;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_req;
  logic       addr_match;
  logic       rw;
  logic       start_det;
  logic       stop_det;
  logic       busy;

  modport slave (
    input  i2c_sclk, rx_nack, tx_data,
    output rx_data, rx_valid, tx_req, addr_match, rw, start_det, stop_det, busy
  );

  modport master (
    output i2c_sclk, rx_nack, tx_data,
    input  rx_data, rx_valid, tx_req, addr_match, rw, start_det, stop_det, busy
  );
endinterface

// File: rtl/i2c_slave_responder.sv
// I2C target: detects START/STOP, ACKs its own 7-bit address, accepts write bytes
// and serves read bytes through a byte-level rx_valid / tx_req handshake.
module i2c_slave_responder #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  inout  wire                   i2c_sda,
  i2c_slave_responder_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK
  } state_t;

  state_t                  state_q;
  logic                    scl_meta_q, scl_s_q, scl_d_q;
  logic                    sda_meta_q, sda_s_q, sda_d_q;
  logic [DATA_WIDTH-1:0]   shreg_q;
  logic [DATA_WIDTH-1:0]   rx_data_q;
  logic [2:0]              bitcnt_q;
  logic                    byte_done_q;
  logic                    mack_q;
  logic                    sda_oe_q;
  logic                    rx_valid_q, tx_req_q, addr_match_q, rw_q;
  logic                    start_det_q, stop_det_q, busy_q;

  logic scl_rise, scl_fall, start_ev, stop_ev;

  assign scl_rise = scl_s_q & ~scl_d_q;
  assign scl_fall = ~scl_s_q & scl_d_q;
  assign start_ev = scl_s_q & scl_d_q & sda_d_q & ~sda_s_q;
  assign stop_ev  = scl_s_q & scl_d_q & ~sda_d_q & sda_s_q;

  // Open-drain pad: the tri-state net stays a plain port so it resolves with the board pull-up.
  assign i2c_sda = sda_oe_q ? 1'b0 : 1'bz;

  assign bus.rx_data    = rx_data_q;
  assign bus.rx_valid   = rx_valid_q;
  assign bus.tx_req     = tx_req_q;
  assign bus.addr_match = addr_match_q;
  assign bus.rw         = rw_q;
  assign bus.start_det  = start_det_q;
  assign bus.stop_det   = stop_det_q;
  assign bus.busy       = busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      scl_meta_q   <= 1'b1;
      scl_s_q      <= 1'b1;
      scl_d_q      <= 1'b1;
      sda_meta_q   <= 1'b1;
      sda_s_q      <= 1'b1;
      sda_d_q      <= 1'b1;
      shreg_q      <= '0;
      rx_data_q    <= '0;
      bitcnt_q     <= 3'd0;
      byte_done_q  <= 1'b0;
      mack_q       <= 1'b0;
      sda_oe_q     <= 1'b0;
      rx_valid_q   <= 1'b0;
      tx_req_q     <= 1'b0;
      addr_match_q <= 1'b0;
      rw_q         <= 1'b0;
      start_det_q  <= 1'b0;
      stop_det_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      scl_meta_q   <= bus.i2c_sclk;
      scl_s_q      <= scl_meta_q;
      scl_d_q      <= scl_s_q;
      sda_meta_q   <= i2c_sda;
      sda_s_q      <= sda_meta_q;
      sda_d_q      <= sda_s_q;
      rx_valid_q   <= 1'b0;
      tx_req_q     <= 1'b0;
      addr_match_q <= 1'b0;
      start_det_q  <= 1'b0;
      stop_det_q   <= 1'b0;

      if (start_ev) begin
        sda_oe_q    <= 1'b0;
        bitcnt_q    <= 3'd0;
        byte_done_q <= 1'b0;
        mack_q      <= 1'b0;
        start_det_q <= 1'b1;
        state_q     <= ADDR;
      end else if (stop_ev) begin
        sda_oe_q    <= 1'b0;
        byte_done_q <= 1'b0;
        mack_q      <= 1'b0;
        stop_det_q  <= 1'b1;
        busy_q      <= 1'b0;
        state_q     <= IDLE;
      end else begin
        case (state_q)
          IDLE: ;
          ADDR, WR_BYTE: begin
            if (scl_rise) begin
              shreg_q  <= {shreg_q[DATA_WIDTH-2:0], sda_s_q};
              bitcnt_q <= bitcnt_q + 3'd1;
              if (bitcnt_q == 3'd7) byte_done_q <= 1'b1;
            end else if (scl_fall && byte_done_q) begin
              byte_done_q <= 1'b0;
              if (state_q == WR_BYTE) begin
                rx_data_q  <= shreg_q;
                rx_valid_q <= 1'b1;
                sda_oe_q   <= ~bus.rx_nack;
                state_q    <= WR_ACK;
              end else if (shreg_q[7:1] == SLAVE_ADDR) begin
                sda_oe_q     <= 1'b1;
                rw_q         <= shreg_q[0];
                addr_match_q <= 1'b1;
                busy_q       <= 1'b1;
                tx_req_q     <= shreg_q[0];
                state_q      <= ADDR_ACK;
              end else begin
                busy_q  <= 1'b0;
                state_q <= IDLE;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              bitcnt_q <= 3'd0;
              if (rw_q) begin
                shreg_q  <= bus.tx_data;
                sda_oe_q <= ~bus.tx_data[7];
                state_q  <= RD_BYTE;
              end else begin
                sda_oe_q <= 1'b0;
                state_q  <= WR_BYTE;
              end
            end
          end
          WR_ACK: begin
            if (scl_fall) begin
              sda_oe_q <= 1'b0;
              bitcnt_q <= 3'd0;
              state_q  <= WR_BYTE;
            end
          end
          RD_BYTE: begin
            // Bit 7 went out on entry; each later fall presents the next bit, the 8th releases.
            if (scl_fall) begin
              if (bitcnt_q == 3'd7) begin
                sda_oe_q <= 1'b0;
                bitcnt_q <= 3'd0;
                state_q  <= RD_ACK;
              end else begin
                shreg_q  <= {shreg_q[DATA_WIDTH-2:0], 1'b0};
                sda_oe_q <= ~shreg_q[DATA_WIDTH-2];
                bitcnt_q <= bitcnt_q + 3'd1;
              end
            end
          end
          RD_ACK: begin
            if (scl_rise) begin
              if (!sda_s_q) begin
                tx_req_q <= 1'b1;
                mack_q   <= 1'b1;
              end else begin
                state_q <= IDLE;
              end
            end else if (scl_fall && mack_q) begin
              mack_q   <= 1'b0;
              shreg_q  <= bus.tx_data;
              sda_oe_q <= ~bus.tx_data[7];
              bitcnt_q <= 3'd0;
              state_q  <= RD_BYTE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule
